// File: rtl/sha256_msg_sched_pkg.sv
// Shared definitions for the SHA-256 message schedule sequencer: state encoding,
// sigma rotation/shift amounts, word width and window depth.
package sha256_msg_sched_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam int WORD_W    = 32;
    localparam int WIN_DEPTH = 16;
    localparam int IDX_W     = 6;

    localparam int S0_ROT_A  = 7;
    localparam int S0_ROT_B  = 18;
    localparam int S0_SHR    = 3;
    localparam int S1_ROT_A  = 17;
    localparam int S1_ROT_B  = 19;
    localparam int S1_SHR    = 10;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Stream interface of the schedule sequencer: 32-bit word input and indexed W[t] output.
interface sha256_msg_sched_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/add4.sv
// Shared 4-input 32-bit adder; sum wraps mod 2^32.
module add4 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] sum
);

    assign sum = a + b + c + d;

endmodule

// File: rtl/sha256_msg_sched_ssig.sv
// Module sha256_ssig: combinational small-sigma function, SEL=0 gives s0, SEL=1 gives s1.
module sha256_ssig
    import sha256_msg_sched_pkg::*;
#(
    parameter int SEL = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam int ROT_A = (SEL == 0) ? S0_ROT_A : S1_ROT_A;
    localparam int ROT_B = (SEL == 0) ? S0_ROT_B : S1_ROT_B;
    localparam int SHR   = (SEL == 0) ? S0_SHR   : S1_SHR;

    assign y = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ (x >> SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, then emits W[0..ROUNDS-1] from a 16-word window.
// Optional block abort input enabled by defining SHA256_SCHED_ABORT_EN.
module sha256_msg_sched
    import sha256_msg_sched_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SHA256_SCHED_ABORT_EN
    input  logic abort,
`endif
    sha256_msg_sched_if.slave sif,
    output logic busy
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] win_q [WIN_DEPTH];

    logic              win_we;
    logic [3:0]        win_waddr;
    logic [WORD_W-1:0] win_wdata;

    logic              abort_w;
    logic              emit;
    logic              use_add;
    logic              last_t;
    logic              in_hs;
    logic              out_hs;
    logic [3:0]        idx_m16, idx_m15, idx_m7, idx_m2;
    logic [WORD_W-1:0] w_m16, w_m15, w_m7, w_m2;
    logic [WORD_W-1:0] s0_w, s1_w, sum_w, word_w;

`ifdef SHA256_SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign emit    = (state_q == ST_EMIT);
    assign use_add = (cnt_q >= 6'd16);
    assign last_t  = (cnt_q == IDX_W'(ROUNDS - 1));
    assign in_hs   = sif.in_valid & ~emit;
    assign out_hs  = sif.out_ready & emit;

    // Window slot t&15 holds W[t-16]; the other taps are the same slot offsets mod 16.
    assign idx_m16 = cnt_q[3:0];
    assign idx_m15 = cnt_q[3:0] + 4'd1;
    assign idx_m7  = cnt_q[3:0] + 4'd9;
    assign idx_m2  = cnt_q[3:0] + 4'd14;

    assign w_m16 = win_q[idx_m16];
    assign w_m15 = win_q[idx_m15];
    assign w_m7  = win_q[idx_m7];
    assign w_m2  = win_q[idx_m2];

    sha256_ssig #(.SEL(0)) u_s0 (.x(w_m15), .y(s0_w));
    sha256_ssig #(.SEL(1)) u_s1 (.x(w_m2),  .y(s1_w));

    add4 u_add4 (
        .a   (s1_w),
        .b   (w_m7),
        .c   (s0_w),
        .d   (w_m16),
        .sum (sum_w)
    );

    assign word_w = use_add ? sum_w : w_m16;

    assign sif.in_ready  = ~emit;
    assign sif.out_valid = emit;
    assign sif.out_data  = emit ? word_w : '0;
    assign sif.out_idx   = emit ? cnt_q : '0;
    assign sif.out_last  = emit & last_t;
    assign busy          = emit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_we    = 1'b0;
        win_waddr = cnt_q[3:0];
        win_wdata = sif.in_data;
        case (state_q)
            ST_LOAD: begin
                if (in_hs) begin
                    win_we = 1'b1;
                    if (cnt_q == 6'd15) begin
                        cnt_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_hs) begin
                    win_we    = use_add;
                    win_wdata = sum_w;
                    if (last_t) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
        endcase
        // Abort wins over any handshake in the same cycle, including its buffer write.
        if (abort_w) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            win_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (win_we) begin
            win_q[win_waddr] <= win_wdata;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched (ROUNDS=64 and ROUNDS=16 instances); abort case
// runs when SHA256_SCHED_ABORT_EN is defined.
module tb_sha256_msg_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha256_msg_sched_if sif_a ();
    sha256_msg_sched_if sif_b ();
    logic busy_a, busy_b;

`ifdef SHA256_SCHED_ABORT_EN
    logic abort;
`endif

    sha256_msg_sched #(.ROUNDS(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SHA256_SCHED_ABORT_EN
        .abort (abort),
`endif
        .sif   (sif_a),
        .busy  (busy_a)
    );

    sha256_msg_sched #(.ROUNDS(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SHA256_SCHED_ABORT_EN
        .abort (abort),
`endif
        .sif   (sif_b),
        .busy  (busy_b)
    );

    int vectors = 0;
    int errs    = 0;

    logic [31:0] blk   [16];
    logic [31:0] blk_n [16];
    logic [31:0] exp_w [64];

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic build_exp();
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = f_s1(exp_w[i-2]) + exp_w[i-7] + f_s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic rand_blk();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Feed blk into the 64-round DUT; optionally leave in_valid high carrying next_word.
    task automatic load_a(input bit hold_valid, input logic [31:0] next_word);
        for (int i = 0; i < 16; i++) begin
            int guard = 0;
            sif_a.in_valid = 1'b1;
            sif_a.in_data  = blk[i];
            while (!sif_a.in_ready && guard < 200) begin
                step();
                guard++;
            end
            chk($sformatf("load_ready[%0d]", i), 32'(sif_a.in_ready), 32'd1);
            step();
        end
        sif_a.in_data  = next_word;
        sif_a.in_valid = hold_valid;
    endtask

    // Accept n_words outputs, comparing against exp_w; throttle randomises out_ready.
    task automatic drain_a(input int n_words, input bit throttle);
        for (int t = 0; t < n_words; t++) begin
            int guard = 0;
            sif_a.out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!(sif_a.out_valid && sif_a.out_ready) && guard < 64) begin
                if (sif_a.out_valid) begin
                    logic [31:0] d_hold;
                    logic [5:0]  i_hold;
                    d_hold = sif_a.out_data;
                    i_hold = sif_a.out_idx;
                    step();
                    chk($sformatf("stall_data[%0d]", t), sif_a.out_data, d_hold);
                    chk($sformatf("stall_idx[%0d]", t), 32'(sif_a.out_idx), 32'(i_hold));
                    chk($sformatf("stall_valid[%0d]", t), 32'(sif_a.out_valid), 32'd1);
                end else begin
                    step();
                end
                guard++;
                sif_a.out_ready = (throttle && guard < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            chk($sformatf("valid[%0d]", t), 32'(sif_a.out_valid), 32'd1);
            chk($sformatf("idx[%0d]", t), 32'(sif_a.out_idx), 32'(t));
            chk($sformatf("data[%0d]", t), sif_a.out_data, exp_w[t]);
            chk($sformatf("last[%0d]", t), 32'(sif_a.out_last), 32'(t == 63));
            chk($sformatf("emit_in_ready[%0d]", t), 32'(sif_a.in_ready), 32'd0);
            chk($sformatf("busy[%0d]", t), 32'(busy_a), 32'd1);
            step();
        end
        sif_a.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        sif_a.in_valid  = 1'b0;
        sif_a.in_data   = '0;
        sif_a.out_ready = 1'b0;
        sif_b.in_valid  = 1'b0;
        sif_b.in_data   = '0;
        sif_b.out_ready = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        step();
        step();
        chk("rst_in_ready",  32'(sif_a.in_ready),  32'd1);
        chk("rst_out_valid", 32'(sif_a.out_valid), 32'd0);
        chk("rst_out_idx",   32'(sif_a.out_idx),   32'd0);
        chk("rst_out_last",  32'(sif_a.out_last),  32'd0);
        chk("rst_busy",      32'(busy_a),          32'd0);
        chk("rst_out_data",  sif_a.out_data,       32'd0);
        rst_n = 1'b1;
        step();

        // "abc" block, out_ready held high; W16/W17 pinned to hand values
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_exp();
        exp_w[16] = 32'h61626380;
        exp_w[17] = 32'h000F0000;
        sif_a.out_ready = 1'b1;
        load_a(1'b0, 32'h0);
        chk("first_valid_latency", 32'(sif_a.out_valid), 32'd1);
        drain_a(64, 1'b0);
        chk("abc_back_to_load", 32'(sif_a.in_ready), 32'd1);
        chk("abc_valid_low",    32'(sif_a.out_valid), 32'd0);

        // Random block unthrottled, then the same block throttled
        rand_blk();
        build_exp();
        load_a(1'b0, 32'h0);
        drain_a(64, 1'b0);
        load_a(1'b0, 32'h0);
        drain_a(64, 1'b1);

        // Back-to-back blocks with in_valid held high across EMIT
        rand_blk();
        for (int i = 0; i < 16; i++) blk_n[i] = $urandom;
        build_exp();
        load_a(1'b1, blk_n[0]);
        drain_a(64, 1'b0);
        chk("b2b_ready_after_last", 32'(sif_a.in_ready), 32'd1);
        for (int i = 0; i < 16; i++) blk[i] = blk_n[i];
        build_exp();
        load_a(1'b0, 32'h0);
        drain_a(64, 1'b1);

        // Reset pulsed at idx 30
        rand_blk();
        build_exp();
        load_a(1'b0, 32'h0);
        drain_a(30, 1'b1);
        chk("pre_rst_idx", 32'(sif_a.out_idx), 32'd30);
        rst_n = 1'b0;
        #1;
        chk("in_rst_valid", 32'(sif_a.out_valid), 32'd0);
        chk("in_rst_ready", 32'(sif_a.in_ready),  32'd1);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_valid", 32'(sif_a.out_valid), 32'd0);
        chk("post_rst_ready", 32'(sif_a.in_ready),  32'd1);
        chk("post_rst_idx",   32'(sif_a.out_idx),   32'd0);
        rand_blk();
        build_exp();
        load_a(1'b0, 32'h0);
        drain_a(64, 1'b0);

        // ROUNDS=16 instance: pure pass-through
        for (int i = 0; i < 16; i++) begin
            int guard = 0;
            sif_b.in_valid = 1'b1;
            sif_b.in_data  = blk[i] ^ 32'hA5A5_0000;
            while (!sif_b.in_ready && guard < 200) begin
                step();
                guard++;
            end
            chk($sformatf("r16_load_ready[%0d]", i), 32'(sif_b.in_ready), 32'd1);
            step();
        end
        sif_b.in_valid  = 1'b0;
        sif_b.out_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            chk($sformatf("r16_valid[%0d]", t), 32'(sif_b.out_valid), 32'd1);
            chk($sformatf("r16_idx[%0d]", t),   32'(sif_b.out_idx),   32'(t));
            chk($sformatf("r16_data[%0d]", t),  sif_b.out_data, blk[t] ^ 32'hA5A5_0000);
            chk($sformatf("r16_last[%0d]", t),  32'(sif_b.out_last),  32'(t == 15));
            step();
        end
        chk("r16_back_to_load", 32'(sif_b.in_ready),  32'd1);
        chk("r16_valid_low",    32'(sif_b.out_valid), 32'd0);
        sif_b.out_ready = 1'b0;

`ifdef SHA256_SCHED_ABORT_EN
        // Abort at idx 20 with out_ready high: the handshake is dropped
        rand_blk();
        build_exp();
        load_a(1'b0, 32'h0);
        drain_a(20, 1'b0);
        chk("abort_at_idx", 32'(sif_a.out_idx), 32'd20);
        sif_a.out_ready = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        sif_a.out_ready = 1'b0;
        chk("abort_valid_low", 32'(sif_a.out_valid), 32'd0);
        chk("abort_in_ready",  32'(sif_a.in_ready),  32'd1);
        chk("abort_idx_zero",  32'(sif_a.out_idx),   32'd0);
        rand_blk();
        build_exp();
        load_a(1'b0, 32'h0);
        drain_a(64, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
